mux8_rr_arbiter: RTL and testbench
==================================

// Module: mux8_rr_arbiter
// PURPOSE
//   Round-robin arbiter sharing one 8:1 single-bit mux between 8 requesters.
//   Drives the mux select lines s2,s1,s0 and a one-hot grant; sits directly upstream of the 8:1 mux.
//   Holds a granted requester until it drops req, then rotates priority to give fair access.
// PARAMETERS
//   MAX_BURST  16  max consecutive grant cycles per owner (used only with ARB_BURST_LIMIT_EN); legal 2..255
//   CNT_W       8  burst counter width; must satisfy 2**CNT_W > MAX_BURST
// PORTS
//   clk    in   1  single clock, all state on posedge
//   rst    in   1  synchronous reset, active-high
//   req    in   8  level request per requester; bit i maps to mux input i
//   gnt    out  8  registered one-hot grant; all-zero when idle
//   s2     out  1  mux select MSB, registered
//   s1     out  1  mux select mid bit, registered
//   s0     out  1  mux select LSB, registered
//   valid  out  1  high while gnt is non-zero; mux output y is meaningful only when valid=1
// BEHAVIOUR
//   Reset: gnt=8'h00, {s2,s1,s0}=3'b000, valid=0, ptr=3'd0, FSM=IDLE, burst count=0. A reset mid-grant drops gnt on the next edge.
//   FSM states:
//     IDLE : any req bit set -> GRANT; winner = first set bit scanning ptr, ptr+1, ... ptr+7 (mod 8).
//     GRANT: stays in GRANT while req[owner]=1 (and burst limit not hit).
//   Owner release: req[owner]=0 seen on edge N.
//     - gnt/valid clear at N. ptr <= owner+1 (mod 8, 3'd7 wraps to 3'd0).
//     - FSM -> IDLE. Re-arbitration occurs at N+1, using the new ptr.
//     - Minimum one idle cycle between owners (bubble). This cycle is required; the mux output is not used during it.
//   Latency: req rising in IDLE at edge N-1 -> gnt, sel and valid all update together at edge N (1 cycle).
//   Select encoding: {s2,s1,s0} = index of the set gnt bit. In IDLE the select holds its last value.
//   Simultaneous requests: resolved by the rotating pointer only; no fixed priority.
//   Non-owner req changes during GRANT: ignored until the next IDLE.
//   Owner drop and re-raise in one cycle: treated as release; the owner competes again from the new ptr.
//   req=8'h00 in IDLE: remain IDLE, outputs unchanged.
// CONFIGURATION
//   ARB_BURST_LIMIT_EN defined:
//     - Burst counter counts grant cycles. When count == MAX_BURST-1 and req[owner] is still 1, the grant is forcibly released on the next edge.
//     - Forced release follows the normal release sequence (ptr advances, one idle bubble). The owner may win again only after the other requesters are scanned.
//   ARB_BURST_LIMIT_EN undefined:
//     - No counter is instantiated. Grant is held indefinitely while req[owner]=1.
// STRUCTURE
//   Shared package (mux8_arb_pkg): NUM_REQ=8, SEL_W=3, FSM state encodings ST_IDLE=1'b0 / ST_GRANT=1'b1,
//   and an onehot-to-index function.
//   Sub-module: rr_pick8. Combinational rotating priority encoder: inputs (req[7:0], ptr[2:0]); outputs (any, idx[2:0]).
//   The top level holds the FSM, ptr, grant/select registers and the optional burst counter.
// TESTING
//   1 rst=1 for 2 cycles with req=8'hFF -> gnt=0, sel=000, valid=0. After release, req=8'h01 -> gnt=8'h01, sel=000 one cycle later.
//   2 req=8'hFF held, each owner drops req for 1 cycle after being granted -> grant order 0,1,2,...,7,0 with a 1-cycle bubble between owners.
//   3 ptr=7 (owner 6 released), req=8'h81 -> gnt=8'h80, sel=111; after release -> gnt=8'h01, sel=000 (wrap-around).
//   4 owner 3 granted, req[5] rises and falls during the grant -> gnt stays 8'h08 throughout; req[5] is never granted.
//   5 (ARB_BURST_LIMIT_EN, MAX_BURST=4) req=8'h06 held -> gnt=8'h02 for exactly 4 cycles, bubble, then 8'h04 for 4 cycles, bubble, then 8'h02.
//   6 rst asserted during GRANT with owner 5 -> next edge gnt=0, valid=0, sel=000; after rst drops with req=8'h20 -> owner 5 granted again from ptr=0.

Source files
------------

// File: rtl/mux8_arb_pkg.sv
// Shared definitions for the 8-requester round-robin mux arbiter.
// Contents: requester count, select width, FSM state encoding and a
// one-hot to index helper used to recover the owner from the grant vector.
package mux8_arb_pkg;

    localparam int unsigned NUM_REQ = 8;
    localparam int unsigned SEL_W   = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // OR of the indices of all set bits; exact for a one-hot input.
    function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | SEL_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational rotating priority encoder for 8 requesters.
// Ports:
//   req [7:0]  request vector
//   ptr [2:0]  highest-priority position for this scan
//   any        at least one request is set
//   idx [2:0]  first set request found scanning ptr, ptr+1, ... ptr+7 (mod 8)
module rr_pick8
    import mux8_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               any,
    output logic [SEL_W-1:0]   idx
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [SEL_W-1:0]     off;

    // Rotate so that bit ptr lands at position 0.
    assign req_dbl = {req, req};
    assign req_rot = NUM_REQ'(req_dbl >> ptr);

    // Lowest set bit of the rotated vector is the winner's offset from ptr.
    always_comb begin
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                off = SEL_W'(i);
            end
        end
    end

    assign any = |req;
    // 3-bit addition wraps modulo 8.
    assign idx = ptr + off;

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 single-bit mux between 8 requesters.
// A granted requester keeps the mux until it drops its request; release
// advances the priority pointer past the owner and always costs one idle
// cycle before the next grant.
// Optional feature macro: ARB_BURST_LIMIT_EN -- caps an ownership at
// MAX_BURST consecutive grant cycles with a forced release.
// Ports:
//   clk          clock, all state on posedge
//   rst          synchronous active-high reset
//   req   [7:0]  level requests, bit i maps to mux input i
//   gnt   [7:0]  registered one-hot grant, zero when idle
//   s2,s1,s0     registered mux select, index of the granted bit
//   valid        registered, high while gnt is non-zero
module mux8_rr_arbiter
    import mux8_arb_pkg::*;
#(
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned CNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               s2,
    output logic               s1,
    output logic               s0,
    output logic               valid
);

    arb_state_e           state_q, state_d;
    logic [SEL_W-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic                 valid_q, valid_d;

    logic                 pick_any;
    logic [SEL_W-1:0]     pick_idx;
    logic [SEL_W-1:0]     owner_idx;
    logic                 burst_hit;

    rr_pick8 u_pick (
        .req (req),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign owner_idx = onehot_to_idx(gnt_q);

`ifdef ARB_BURST_LIMIT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Last permitted grant cycle of the current ownership.
    assign burst_hit = (cnt_q == CNT_W'(MAX_BURST - 1));
`else
    logic unused_burst_cfg;

    assign burst_hit        = 1'b0;
    assign unused_burst_cfg = ^CNT_W'(MAX_BURST);
`endif

    // Next-state, grant and pointer logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        valid_d = valid_q;
`ifdef ARB_BURST_LIMIT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_GRANT;
                    gnt_d   = NUM_REQ'(1) << pick_idx;
                    sel_d   = pick_idx;
                    valid_d = 1'b1;
`ifdef ARB_BURST_LIMIT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_GRANT: begin
                if (!req[owner_idx] || burst_hit) begin
                    // Release: select holds its value, pointer moves past owner.
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    valid_d = 1'b0;
                    ptr_d   = owner_idx + SEL_W'(1);
                end else begin
`ifdef ARB_BURST_LIMIT_EN
                    cnt_d   = cnt_q + CNT_W'(1);
`endif
                end
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
        end
    end

`ifdef ARB_BURST_LIMIT_EN
    // Burst counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign gnt          = gnt_q;
    assign {s2, s1, s0} = sel_q;
    assign valid        = valid_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Testbench for mux8_rr_arbiter. Stimulus pushes the expected grant episodes
// (grant vector, select, length in cycles) into a queue; an independent
// monitor detects each episode on the DUT outputs and checks it against the
// queue, along with idle-select hold and valid/gnt agreement every cycle.
module tb_mux8_rr_arbiter;
    import mux8_arb_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic       s2, s1, s0;
    logic       valid;
    logic [2:0] sel_w;

    typedef struct {
        logic [7:0] g;
        logic [2:0] s;
        int         len;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    assign sel_w = {s2, s1, s0};

    mux8_rr_arbiter #(
        .MAX_BURST (4),
        .CNT_W     (8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .gnt   (gnt),
        .s2    (s2),
        .s1    (s1),
        .s0    (s0),
        .valid (valid)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] g, input logic [2:0] s, input int len);
        exp_t e;
        e.g   = g;
        e.s   = s;
        e.len = len;
        sb.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin : monitor
        logic       prev_valid;
        logic       rst_prev;
        logic [7:0] cur_g;
        logic [2:0] cur_s;
        logic [2:0] idle_sel;
        int         len;
        exp_t       e;
        prev_valid = 1'b0;
        rst_prev   = 1'b1;
        cur_g      = '0;
        cur_s      = '0;
        idle_sel   = '0;
        len        = 0;
        forever begin
            @(negedge clk);
            check("valid_vs_gnt", 32'(valid), 32'(gnt != 8'h00));
            if (valid && !prev_valid) begin
                cur_g = gnt;
                cur_s = sel_w;
                len   = 1;
            end else if (valid && prev_valid) begin
                check("gnt_stable", 32'(gnt), 32'(cur_g));
                check("sel_stable", 32'(sel_w), 32'(cur_s));
                len++;
            end else if (!valid && prev_valid) begin
                idle_sel = cur_s;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_grant actual=%0h required=none at %0t", cur_g, $time);
                end else begin
                    e = sb.pop_front();
                    check("ep_gnt", 32'(cur_g), 32'(e.g));
                    check("ep_sel", 32'(cur_s), 32'(e.s));
                    check("ep_len", 32'(len), 32'(e.len));
                end
            end
            if (rst_prev) begin
                idle_sel = '0;
            end
            if (!valid) begin
                check("idle_sel_hold", 32'(sel_w), 32'(idle_sel));
            end
            prev_valid = valid;
            rst_prev   = rst;
        end
    end

    // Stimulus.
    initial begin : stim
        rst = 1'b1;
        req = 8'hFF;

        // 1: reset with all requests, then a single request.
        cyc(2);
        check("rst_gnt", 32'(gnt), 32'h00);
        check("rst_sel", 32'(sel_w), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        rst = 1'b0;
        req = 8'h01;
        cyc(1);
        check("t1_gnt", 32'(gnt), 32'h01);
        check("t1_sel", 32'(sel_w), 32'h0);
        check("t1_valid", 32'(valid), 32'h1);
        push(8'h01, 3'd0, 1);
        req = 8'h00;
        cyc(1);

        // 2: all requesting, each owner drops for one cycle -> 0..7,0.
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        req = 8'hFF;
        cyc(1);
        for (int k = 0; k < 9; k++) begin
            logic [7:0] bit_k;
            bit_k = 8'h01 << (k % 8);
            push(bit_k, 3'(k % 8), 1);
            req = 8'hFF & ~bit_k;
            cyc(1);
            req = (k < 8) ? 8'hFF : 8'h00;
            cyc(1);
        end

        // 3: owner 6 released -> ptr=7, then wrap-around 7 -> 0.
        req = 8'h40;
        cyc(1);
        push(8'h40, 3'd6, 1);
        req = 8'h00;
        cyc(1);
        req = 8'h81;
        cyc(1);
        check("t3_gnt7", 32'(gnt), 32'h80);
        check("t3_sel7", 32'(sel_w), 32'h7);
        push(8'h80, 3'd7, 1);
        req = 8'h01;
        cyc(2);
        check("t3_gnt0", 32'(gnt), 32'h01);
        push(8'h01, 3'd0, 1);
        req = 8'h00;
        cyc(1);

        // 4: owner 3, req[5] pulses during the grant and is never served.
        req = 8'h08;
        cyc(1);
        push(8'h08, 3'd3, 4);
        req = 8'h28;
        cyc(2);
        req = 8'h08;
        cyc(1);
        req = 8'h00;
        cyc(3);

        // 6: reset during a grant held by owner 5, then regrant from ptr=0.
        req = 8'h20;
        cyc(1);
        push(8'h20, 3'd5, 2);
        cyc(1);
        rst = 1'b1;
        cyc(1);
        check("t6_rst_gnt", 32'(gnt), 32'h00);
        check("t6_rst_valid", 32'(valid), 32'h0);
        check("t6_rst_sel", 32'(sel_w), 32'h0);
        rst = 1'b0;
        cyc(1);
        check("t6_regnt", 32'(gnt), 32'h20);
        check("t6_resel", 32'(sel_w), 32'h5);
        push(8'h20, 3'd5, 1);
        req = 8'h00;
        cyc(2);

`ifdef ARB_BURST_LIMIT_EN
        // 5: burst limit of 4 alternates owners 1 and 2.
        req = 8'h06;
        cyc(1);
        push(8'h02, 3'd1, 4);
        cyc(5);
        push(8'h04, 3'd2, 4);
        cyc(5);
        push(8'h02, 3'd1, 4);
        cyc(3);
        req = 8'h00;
        cyc(1);
`endif

        cyc(4);
        check("sb_empty", 32'(sb.size()), 32'h0);
        check("end_valid", 32'(valid), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
